// File: rtl/router_1xn.sv
// router_1xn: routes framed packets (header, payload, parity) into one of NUM_PORTS
// first-word-fall-through FIFOs. Optional stale-FIFO flush: define ROUTER_SOFT_RESET_EN.
module router_1xn #(
    parameter int DATA_W     = 8,
    parameter int NUM_PORTS  = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        pkt_valid,
    input  logic [DATA_W-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]        read_en,
    output logic                        busy,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        vld_out,
    output logic                        parity_err,
    output logic                        dest_err,
    output logic [NUM_PORTS-1:0]        soft_reset
);
    localparam int DEST_W = $clog2(NUM_PORTS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [DEST_W:0]  PORT_LIMIT = (DEST_W + 1)'(NUM_PORTS);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, DROP, PARITY, CHECK} state_t;

    state_t              state_reg;
    logic [DEST_W-1:0]   dest_reg;
    logic                dropped_reg;
    logic [DATA_W-1:0]   parity_calc_reg;
    logic [DATA_W-1:0]   parity_beat_reg;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] flush;
    logic [DEST_W-1:0]   hdr_dest;
    logic                consume;

    assign hdr_dest = data_in[DEST_W-1:0];
    // Full is judged on current occupancy, so a same-cycle pop does not release the stall.
    assign busy     = (state_reg == CHECK) || ((state_reg == LOAD) && full[dest_reg]);
    assign consume  = !busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= IDLE;
            dest_reg        <= '0;
            dropped_reg     <= 1'b0;
            parity_calc_reg <= '0;
            parity_beat_reg <= '0;
            parity_err      <= 1'b0;
            dest_err        <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            dest_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pkt_valid) begin
                        parity_calc_reg <= data_in;
                        dest_reg        <= hdr_dest;
                        if ({1'b0, hdr_dest} < PORT_LIMIT) begin
                            state_reg   <= LOAD;
                            dropped_reg <= 1'b0;
                        end else begin
                            state_reg   <= DROP;
                            dropped_reg <= 1'b1;
                            dest_err    <= 1'b1;
                        end
                    end
                end
                LOAD, DROP: begin
                    if (consume) begin
                        if (pkt_valid) begin
                            parity_calc_reg <= parity_calc_reg ^ data_in;
                        end else begin
                            parity_beat_reg <= data_in;
                            state_reg       <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    state_reg  <= CHECK;
                    parity_err <= !dropped_reg && (parity_beat_reg != parity_calc_reg);
                end
                CHECK:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        localparam logic [DEST_W-1:0] PORT_ID = DEST_W'(gi);

        logic [DATA_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_reg;
        logic [PTR_W-1:0]  rd_ptr_reg;
        logic [CNT_W-1:0]  count_reg;
        logic              push;
        logic              pop;

        assign full[gi]    = (count_reg == FULL_CNT);
        assign vld_out[gi] = (count_reg != '0);
        assign data_out[gi*DATA_W +: DATA_W] = vld_out[gi] ? mem[rd_ptr_reg] : '0;

        // A flush wins over both the incoming beat and any pop in the same cycle.
        assign push = (state_reg == LOAD) && consume && pkt_valid &&
                      (dest_reg == PORT_ID) && !flush[gi];
        assign pop  = read_en[gi] && vld_out[gi] && !flush[gi];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= data_in;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else if (flush[gi]) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                if (push && !pop) begin
                    count_reg <= count_reg + 1'b1;
                end else if (!push && pop) begin
                    count_reg <= count_reg - 1'b1;
                end
            end
        end

`ifdef ROUTER_SOFT_RESET_EN
        logic [4:0] stale_cnt_reg;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                stale_cnt_reg <= '0;
            end else if (!vld_out[gi] || read_en[gi] || flush[gi]) begin
                stale_cnt_reg <= '0;
            end else begin
                stale_cnt_reg <= stale_cnt_reg + 1'b1;
            end
        end

        assign flush[gi] = (stale_cnt_reg == 5'd30);
`else
        assign flush[gi] = 1'b0;
`endif
        assign soft_reset[gi] = flush[gi];
    end
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: vector table, directed corner sequences and random packets for
// router_1xn, checked against a per-port queue model of delivered payload.
module tb_router_1xn;
    localparam int DW    = 8;
    localparam int NP    = 3;
    localparam int DEPTH = 16;
    localparam int DB    = $clog2(NP);

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            pkt_valid = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic [NP-1:0]   read_en = '0;
    logic            busy;
    logic [NP*DW-1:0] data_out;
    logic [NP-1:0]   vld_out;
    logic            parity_err;
    logic            dest_err;
    logic [NP-1:0]   soft_reset;

    router_1xn #(.DATA_W(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .read_en(read_en), .busy(busy), .data_out(data_out), .vld_out(vld_out),
        .parity_err(parity_err), .dest_err(dest_err), .soft_reset(soft_reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    bit rand_rd  = 1'b0;

    // Model: what each port must hold, oldest first.
    logic [DW-1:0] mq [NP][256];
    int mh [NP];
    int mt [NP];

    typedef struct packed {
        logic [DW-1:0]        hdr;
        logic [3:0][DW-1:0]   pay;
        logic [2:0]           n;
        logic [DW-1:0]        par;
        logic [1:0]           port;   // 3 = nothing delivered
        logic                 perr;
        logic                 derr;
    } vec_t;
    vec_t vecs [7];

    function automatic int msize(input int p);
        if (p < 0) return 0;
        return mt[p] - mh[p];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input int p, input logic [DW-1:0] d);
        mq[p][mt[p] % 256] = d;
        mt[p]++;
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            mh[p] = 0;
            mt[p] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("vld_out[%0d]", p), vld_out[p], msize(p) != 0);
                check($sformatf("data_out[%0d]", p), data_out[p*DW +: DW],
                      (msize(p) != 0) ? mq[p][mh[p] % 256] : '0);
            end
        end
    end

    // One clock: busy and pops are judged on pre-edge state, model updated after the edge.
    task automatic cycle(output logic busy_s);
        logic [NP-1:0] pops;
        if (rand_rd) read_en = NP'($urandom_range(0, (1 << NP) - 1));
        busy_s = busy;
        for (int p = 0; p < NP; p++) pops[p] = read_en[p] && (msize(p) != 0);
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) if (pops[p]) mh[p]++;
    endtask

    task automatic drive_beat(input logic v, input logic [DW-1:0] d, input int store_port,
                              input int busy_port, input string tag);
        logic b;
        int guard;
        guard = 0;
        pkt_valid = v;
        data_in   = d;
        do begin
            check({tag, " busy"}, busy, (busy_port >= 0) ? (msize(busy_port) == DEPTH) : 1'b0);
            cycle(b);
            guard++;
        end while (b && guard < 200);
        if (b) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: beat not accepted within 200 cycles", tag);
        end else if (store_port >= 0) begin
            model_push(store_port, d);
        end
    endtask

    task automatic post_parity(input string tag, output logic perr);
        logic b;
        pkt_valid = 1'b0;
        data_in   = '0;
        check({tag, " parity_err@PARITY"}, parity_err, 1'b0);
        check({tag, " busy@PARITY"}, busy, 1'b0);
        check({tag, " dest_err@PARITY"}, dest_err, 1'b0);
        cycle(b);
        perr = parity_err;
        check({tag, " busy@CHECK"}, busy, 1'b1);
        cycle(b);
        check({tag, " parity_err@IDLE"}, parity_err, 1'b0);
        check({tag, " busy@IDLE"}, busy, 1'b0);
    endtask

    task automatic send_packet(input logic [DW-1:0] hdr, input logic [DW-1:0] pay [32],
                               input int n, input logic [DW-1:0] par, input string tag,
                               output logic perr, output logic derr);
        int d;
        int sp;
        d  = int'(hdr[DB-1:0]);
        sp = (d < NP) ? d : -1;
        drive_beat(1'b1, hdr, -1, -1, {tag, " hdr"});
        derr = dest_err;
        for (int i = 0; i < n; i++) drive_beat(1'b1, pay[i], sp, sp, {tag, " pay"});
        drive_beat(1'b0, par, -1, sp, {tag, " par"});
        post_parity(tag, perr);
    endtask

    task automatic drain_check(input int p, input logic [DW-1:0] exp [32], input int n,
                               input string tag);
        logic b;
        for (int i = 0; i < n; i++) begin
            check({tag, " vld"}, vld_out[p], 1'b1);
            check({tag, " data"}, data_out[p*DW +: DW], exp[i]);
            read_en = NP'(1 << p);
            cycle(b);
            read_en = '0;
        end
        check({tag, " empty"}, vld_out[p], 1'b0);
    endtask

    initial begin
        logic [DW-1:0] pay [32];
        logic [DW-1:0] x;
        logic [DW-1:0] hdr;
        logic perr, derr, b;
        int n, d, guard;

        vecs[0] = '{hdr: 8'h01, pay: 32'h00332211, n: 3'd3, par: 8'h01, port: 2'd1, perr: 1'b0, derr: 1'b0};
        vecs[1] = '{hdr: 8'h01, pay: 32'h00332211, n: 3'd3, par: 8'hFF, port: 2'd1, perr: 1'b1, derr: 1'b0};
        vecs[2] = '{hdr: 8'h03, pay: 32'h77665544, n: 3'd4, par: 8'h00, port: 2'd3, perr: 1'b0, derr: 1'b1};
        vecs[3] = '{hdr: 8'h00, pay: 32'h00000000, n: 3'd0, par: 8'h00, port: 2'd0, perr: 1'b0, derr: 1'b0};
        vecs[4] = '{hdr: 8'h06, pay: 32'h00003412, n: 3'd2, par: 8'h21, port: 2'd2, perr: 1'b1, derr: 1'b0};
        vecs[5] = '{hdr: 8'h40, pay: 32'h0000F00F, n: 3'd2, par: 8'hBF, port: 2'd0, perr: 1'b0, derr: 1'b0};
        vecs[6] = '{hdr: 8'h02, pay: 32'h000000A5, n: 3'd1, par: 8'hA7, port: 2'd2, perr: 1'b0, derr: 1'b0};

        // Reset state
        #12;
        check("reset busy", busy, 1'b0);
        check("reset vld_out", vld_out, '0);
        check("reset data_out", data_out, '0);
        check("reset parity_err", parity_err, 1'b0);
        check("reset dest_err", dest_err, 1'b0);
        check("reset soft_reset", soft_reset, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_clear();
        mon_en = 1'b1;

        // Vector table
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 32; i++) pay[i] = (i < 4) ? vecs[v].pay[i] : '0;
            send_packet(vecs[v].hdr, pay, int'(vecs[v].n), vecs[v].par,
                        $sformatf("vec%0d", v), perr, derr);
            check($sformatf("vec%0d parity_err", v), perr, vecs[v].perr);
            check($sformatf("vec%0d dest_err", v), derr, vecs[v].derr);
            if (vecs[v].port != 2'd3) begin
                drain_check(int'(vecs[v].port), pay, int'(vecs[v].n), $sformatf("vec%0d drain", v));
            end
            check($sformatf("vec%0d all empty", v), vld_out, '0);
        end

        // 20 beats into a 16-deep FIFO with reads held off
        read_en = '0;
        x = 8'h00;
        drive_beat(1'b1, 8'h00, -1, -1, "fill hdr");
        for (int i = 1; i <= 16; i++) begin
            drive_beat(1'b1, DW'(i), 0, 0, "fill pay");
            x ^= DW'(i);
        end
        pkt_valid = 1'b1;
        data_in   = 8'd17;
        for (int k = 0; k < 4; k++) begin
            check("fill busy while full", busy, 1'b1);
            cycle(b);
        end
        check("fill head", data_out[DW-1:0], 8'd1);
        read_en = 3'b001;
        for (int i = 17; i <= 20; i++) begin
            drive_beat(1'b1, DW'(i), 0, 0, "fill late");
            x ^= DW'(i);
        end
        drive_beat(1'b0, x, -1, 0, "fill par");
        post_parity("fill", perr);
        check("fill parity_err", perr, 1'b0);
        guard = 0;
        while (msize(0) > 0 && guard < 100) begin
            cycle(b);
            guard++;
        end
        read_en = '0;
        check("fill drained", vld_out[0], 1'b0);

        // Reset in the middle of a packet to port 2
        drive_beat(1'b1, 8'h02, -1, -1, "rst hdr");
        drive_beat(1'b1, 8'hC1, 2, 2, "rst pay");
        drive_beat(1'b1, 8'hC2, 2, 2, "rst pay");
        check("rst pre vld_out[2]", vld_out[2], 1'b1);
        mon_en = 1'b0;
        resetn = 1'b0;
        model_clear();
        #1;
        check("rst vld_out[2]", vld_out[2], 1'b0);
        check("rst data_out", data_out, '0);
        check("rst busy", busy, 1'b0);
        pkt_valid = 1'b0;
        data_in   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 32; i++) pay[i] = '0;
        pay[0] = 8'h5A;
        pay[1] = 8'h3C;
        send_packet(8'h00, pay, 2, 8'h66, "post-rst", perr, derr);
        check("post-rst parity_err", perr, 1'b0);
        check("post-rst dest_err", derr, 1'b0);
        drain_check(0, pay, 2, "post-rst drain");

        // One beat left unread on port 1
        drive_beat(1'b1, 8'h01, -1, -1, "stale hdr");
        drive_beat(1'b1, 8'h99, 1, 1, "stale pay");
        pkt_valid = 1'b0;
        data_in   = 8'h98;
        for (int k = 1; k <= 31; k++) begin
            cycle(b);
            pkt_valid = 1'b0;
            data_in   = '0;
`ifdef ROUTER_SOFT_RESET_EN
            if (k == 31) mh[1] = mt[1];
            check($sformatf("stale soft_reset k=%0d", k), soft_reset[1], k == 30);
            check($sformatf("stale vld_out k=%0d", k), vld_out[1], k <= 30);
`else
            check($sformatf("stale soft_reset k=%0d", k), soft_reset[1], 1'b0);
            check($sformatf("stale vld_out k=%0d", k), vld_out[1], 1'b1);
`endif
        end
`ifndef ROUTER_SOFT_RESET_EN
        pay[0] = 8'h99;
        drain_check(1, pay, 1, "stale drain");
`endif

        // Random packets with random reads
        rand_rd = 1'b1;
        for (int pk = 0; pk < 40; pk++) begin
            d   = $urandom_range(0, 3);
            hdr = DW'($urandom);
            hdr[DB-1:0] = DB'(d);
            n   = $urandom_range(0, 20);
            x   = hdr;
            for (int i = 0; i < 32; i++) pay[i] = '0;
            for (int i = 0; i < n; i++) begin
                pay[i] = DW'($urandom);
                x ^= pay[i];
            end
            if ($urandom_range(0, 3) == 0) hdr = hdr; // keep header, corrupt parity below
            send_packet(hdr, pay, n, ($urandom_range(0, 3) == 0) ? ~x : x,
                        $sformatf("rnd%0d", pk), perr, derr);
            check($sformatf("rnd%0d dest_err", pk), derr, d >= NP);
        end
        rand_rd = 1'b0;
        read_en = '1;
        guard = 0;
        while ((msize(0) + msize(1) + msize(2)) > 0 && guard < 200) begin
            cycle(b);
            guard++;
        end
        read_en = '0;
        check("final all empty", vld_out, '0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/router_1xn.md
ROUTER_1XN -- requirements
Module: router_1xn

Interface
REQ-001 SHALL have parameter DATA_W, default 8, beat width in bits (>=4).
REQ-002 SHALL have parameter NUM_PORTS, default 3, output port count (2..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries per port FIFO (power of 2, >=4).
REQ-004 SHALL have ports: clk  in  1  clock, rising edge; resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: pkt_valid  in  1  packet framing; data_in  in  DATA_W  header/payload/parity beat.
REQ-006 SHALL have ports: read_en  in  NUM_PORTS  per-port pop request; busy  out  1  input stall.
REQ-007 SHALL have ports: data_out  out  NUM_PORTS*DATA_W  port i at bits [i*DATA_W +: DATA_W]; vld_out  out  NUM_PORTS  port FIFO non-empty.
REQ-008 SHALL have ports: parity_err  out  1  pulse; dest_err  out  1  pulse; soft_reset  out  NUM_PORTS  timeout flush pulse.

Function
REQ-009 SHALL use packet format: header = first pkt_valid-high beat from IDLE, dest = header[clog2(NUM_PORTS)-1:0]; payload = following pkt_valid-high beats; parity = first pkt_valid-low beat after header.
REQ-010 SHALL implement FSM states IDLE, LOAD, DROP, PARITY, CHECK; a beat is consumed only on a clk edge with busy low.
REQ-011 SHALL transition IDLE->LOAD on consumed header with dest < NUM_PORTS; IDLE->DROP on consumed header with dest >= NUM_PORTS.
REQ-012 SHALL transition LOAD->PARITY and DROP->PARITY when pkt_valid is low (zero-length packet: the beat right after header is parity).
REQ-013 SHALL transition PARITY->CHECK after sampling parity beat; CHECK->IDLE unconditionally.
REQ-014 SHALL write each consumed LOAD payload beat into FIFO[dest]; header and parity beats are not stored.
REQ-015 SHALL drive busy high in LOAD when FIFO[dest] is full (full evaluated before same-cycle pop) and in CHECK; low otherwise; sender holds data_in/pkt_valid while busy.
REQ-016 SHALL discard DROP payload beats and pulse dest_err for one cycle the cycle after the bad header is consumed; parity of dropped packets is not checked.
REQ-017 SHALL compute parity_calc = XOR of header and all consumed payload beats, DATA_W wide.
REQ-018 SHALL pulse parity_err for one cycle in CHECK when sampled parity beat != parity_calc (LOAD path only).
REQ-019 SHALL present FIFO head on data_out[i] (first-word-fall-through) with vld_out[i] high while FIFO i non-empty; data_out[i] = 0 when empty.
REQ-020 SHALL pop FIFO i on read_en[i] && vld_out[i]; next entry visible the following cycle; read_en on empty FIFO is ignored.
REQ-021 SHALL allow simultaneous write and pop on one FIFO; occupancy unchanged, order preserved.
REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH with a separate occupancy count of clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-023 SHALL, on resetn low (any time, including mid-packet), asynchronously force FSM IDLE, empty all FIFOs, parity_calc = 0, busy = 0, vld_out = 0, data_out = 0, parity_err = 0, dest_err = 0, soft_reset = 0.
REQ-024 SHALL resume after reset release by treating the next pkt_valid-high beat as a header.

Configuration
REQ-025 SHALL, with ROUTER_SOFT_RESET_EN defined, count per port cycles with vld_out[i] high and read_en[i] low; counter clears on pop or empty.
REQ-026 SHALL, with ROUTER_SOFT_RESET_EN defined, flush FIFO i and pulse soft_reset[i] for one cycle when its counter reaches 30; a same-cycle write to FIFO i is dropped, later beats of the packet are still written.
REQ-027 SHALL, without ROUTER_SOFT_RESET_EN, omit counters and tie soft_reset to 0.

Verification
REQ-028 SHALL cover header 0x01 + payload 0x11,0x22,0x33 + parity 0x01 (correct XOR) -> port 1 vld_out high, reads yield 0x11,0x22,0x33, parity_err stays 0.
REQ-029 SHALL cover same packet with parity 0xFF -> one-cycle parity_err in CHECK, data still delivered to port 1.
REQ-030 SHALL cover header 0x03 with NUM_PORTS=3 and 4 payload beats -> dest_err one-cycle pulse, no vld_out asserted on any port.
REQ-031 SHALL cover 20-beat payload to port 0, no reads, FIFO_DEPTH=16 -> busy high after beat 16, beats 17-20 accepted in order once reads begin.
REQ-032 SHALL cover resetn low after 2 payload beats to port 2 -> vld_out[2]=0 immediately; next packet to port 0 routes correctly.
REQ-033 SHALL cover, with ROUTER_SOFT_RESET_EN, one beat in port 1 unread for 30 cycles -> soft_reset[1] pulse, vld_out[1] low next cycle.
